// File: rtl/calc_job_scheduler_if.sv
// Requester-side bundle of the job scheduler: level requests with their
// entries, the one-cycle grant, and the valid/ready result response.
interface calc_job_scheduler_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] entry_bus;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [7:0]        rsp_data;
  logic              rsp_err;

  // Requester side.
  modport master (
    output req, entry_bus, rsp_ready,
    input  grant, rsp_valid, rsp_data, rsp_err
  );

  // Scheduler side.
  modport slave (
    input  req, entry_bus, rsp_ready,
    output grant, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/calc_job_scheduler.sv
// Shares one calculation engine among NREQ requesters. Round-robin
// arbitration, one job in flight, watchdog abort of hung engine runs, and a
// valid/ready response back to the winner. All outputs are registered.
module calc_job_scheduler #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  calc_job_scheduler_if.slave  bus,
  output logic                 eng_start,
  output logic [3:0]           eng_entry,
  input  logic                 eng_done,
  input  logic [7:0]           eng_result,
  output logic                 eng_abort,
  output logic                 busy,
  output logic [7:0]           jobs_done
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam logic [TW-1:0] WdLast = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StBusy, StDeliver} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]   wdog_q, wdog_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            eng_start_q, eng_start_d;
  logic [3:0]      eng_entry_q, eng_entry_d;
  logic            eng_abort_q, eng_abort_d;
  logic            busy_q, busy_d;
  logic [7:0]      jobs_q, jobs_d;

  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  int unsigned     cand_sum;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   ptr_after_owner;

  // Round-robin pick: first set request scanning upward from rr_ptr, wrapping at NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_sum   = 0;
    cand       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand_sum = 32'(rr_ptr_q) + k;
      if (cand_sum >= NREQ) begin
        cand_sum = cand_sum - NREQ;
      end
      cand = cand_sum[PW-1:0];
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Pointer value that makes the current owner the lowest priority next time.
  always_comb begin
    if (owner_q == PW'(NREQ - 1)) begin
      ptr_after_owner = '0;
    end else begin
      ptr_after_owner = owner_q + PW'(1);
    end
  end

  // Next-state and registered-output logic of the scheduler FSM.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    wdog_d      = wdog_q;
    grant_d     = '0;
    eng_start_d = 1'b0;
    eng_abort_d = 1'b0;
    eng_entry_d = eng_entry_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    jobs_d      = jobs_q;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          owner_d           = pick_idx;
          eng_entry_d       = bus.entry_bus[{pick_idx, 2'b00} +: 4];
          grant_d[pick_idx] = 1'b1;
          eng_start_d       = 1'b1;
          state_d           = StLaunch;
        end
      end
      StLaunch: begin
        // eng_done is deliberately not looked at while the start pulse is out.
        wdog_d  = '0;
        state_d = StBusy;
      end
      StBusy: begin
        wdog_d = wdog_q + TW'(1);
        // A completion on the last watchdog cycle beats the timeout.
        if (eng_done) begin
          rsp_data_d           = eng_result;
          rsp_err_d            = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = StDeliver;
        end else if (wdog_q == WdLast) begin
          eng_abort_d          = 1'b1;
          rsp_data_d           = 8'hFF;
          rsp_err_d            = 1'b1;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = StDeliver;
        end
      end
      StDeliver: begin
        if (bus.rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          jobs_d      = jobs_q + 8'd1;
          rr_ptr_d    = ptr_after_owner;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset clears every output at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      wdog_q      <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      eng_start_q <= 1'b0;
      eng_entry_q <= '0;
      eng_abort_q <= 1'b0;
      busy_q      <= 1'b0;
      jobs_q      <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      wdog_q      <= wdog_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      eng_start_q <= eng_start_d;
      eng_entry_q <= eng_entry_d;
      eng_abort_q <= eng_abort_d;
      busy_q      <= busy_d;
      jobs_q      <= jobs_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign eng_start     = eng_start_q;
  assign eng_entry     = eng_entry_q;
  assign eng_abort     = eng_abort_q;
  assign busy          = busy_q;
  assign jobs_done     = jobs_q;

endmodule

// File: tb/tb_calc_job_scheduler.sv
// Bench for calc_job_scheduler: a requester driver and engine model feed the
// DUT, expected responses are queued per requester at issue time, and a
// negedge monitor checks grants, responses, watchdog aborts and counters.
module tb_calc_job_scheduler;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 20;
  localparam int unsigned TW      = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       eng_start, eng_abort, eng_done, busy;
  logic [3:0] eng_entry;
  logic [7:0] eng_result, jobs_done;

  calc_job_scheduler_if #(.NREQ(NREQ)) bus ();

  calc_job_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .eng_start (eng_start),
    .eng_entry (eng_entry),
    .eng_done  (eng_done),
    .eng_result(eng_result),
    .eng_abort (eng_abort),
    .busy      (busy),
    .jobs_done (jobs_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat;   // cycles from grant to first rsp_valid
  } exp_t;

  exp_t       exp_q  [NREQ][$];
  logic [3:0] todo_q [NREQ][$];
  int         grant_log[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         abort_cnt = 0;
  int         eng_mode = 0;    // 0 done after 10, 1 done on last watchdog cycle, 2 hang
  int         ready_mode = 0;  // 0 all ready, 1 random, 2 ready_man
  logic [NREQ-1:0] ready_man = '1;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (eng_abort === 1'b1) abort_cnt <= abort_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int w);
    onehot = NREQ'(1) << w;
  endfunction

  function automatic bit req_bit(input logic [NREQ-1:0] v, input int idx);
    logic [NREQ-1:0] s;
    s = v >> idx;
    return s[0];
  endfunction

  function automatic logic [3:0] ent_at(input logic [4*NREQ-1:0] v, input int w);
    logic [4*NREQ-1:0] s;
    s = v >> (4 * w);
    return s[3:0];
  endfunction

  // Expected response of a job, from the engine model's behaviour.
  function automatic exp_t make_exp(input logic [3:0] e);
    exp_t r;
    r.data = {4'd0, e} * 8'd2 + 8'd1;
    r.err  = 1'b0;
    r.lat  = 11;
    if (eng_mode == 1) r.lat = TIMEOUT + 1;
    if (eng_mode == 2) begin
      r.data = 8'hFF;
      r.err  = 1'b1;
      r.lat  = TIMEOUT + 1;
    end
    return r;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++)
      if (todo_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Engine model: done pulses a fixed number of cycles after start.
  initial begin : engine
    int rem;
    logic [3:0] ent;
    rem = -1;
    ent = '0;
    eng_done = 1'b0;
    eng_result = '0;
    forever begin
      @(posedge clk); #1;
      eng_done = 1'b0;
      if (!rst || eng_abort) begin
        rem = -1;
      end else if (eng_start) begin
        ent = eng_entry;
        rem = (eng_mode == 0) ? 10 : (eng_mode == 1) ? TIMEOUT : -1;
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          eng_done   = 1'b1;
          eng_result = {4'd0, ent} * 8'd2 + 8'd1;
          rem        = -1;
        end
      end
    end
  end

  // Requester driver: each requester holds req until grant, then takes its next job.
  initial begin : driver
    logic [3:0] e;
    bus.req = '0;
    bus.entry_bus = '0;
    bus.rsp_ready = '0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.rsp_ready = '1;
        1:       bus.rsp_ready = NREQ'($urandom);
        default: bus.rsp_ready = ready_man;
      endcase
      for (int i = 0; i < NREQ; i++) begin
        if (!rst) begin
          bus.req[i] = 1'b0;
        end else begin
          if (bus.grant[i]) bus.req[i] = 1'b0;
          if (!bus.req[i] && todo_q[i].size() > 0) begin
            e = todo_q[i].pop_front();
            bus.entry_bus[4*i +: 4] = e;
            bus.req[i] = 1'b1;
            exp_q[i].push_back(make_exp(e));
          end
        end
      end
    end
  end

  // Monitor: model arbitration and pop expected responses as the DUT presents them.
  initial begin : monitor
    logic [NREQ-1:0]   prev_req;
    logic [4*NREQ-1:0] prev_ent;
    bit                prev_idle, active, dlv, hs;
    int                ptr, jobs, owner, gcyc, w;
    logic [7:0]        hdata;
    logic              herr;
    exp_t              e;
    prev_req = '0; prev_ent = '0; prev_idle = 1'b1;
    active = 1'b0; dlv = 1'b0; hs = 1'b0;
    ptr = 0; jobs = 0; owner = 0; gcyc = 0;
    hdata = '0; herr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < NREQ; i++) exp_q[i].delete();
        ptr = 0; jobs = 0; active = 1'b0; dlv = 1'b0; hs = 1'b0;
        prev_req = '0; prev_idle = 1'b1;
      end else begin
        if (hs) begin
          hs = 1'b0; dlv = 1'b0; active = 1'b0;
          jobs++;
          ptr = (owner + 1) % NREQ;
          chk("rsp_valid_clear", bus.rsp_valid, '0);
        end
        if (prev_idle && prev_req != '0) begin
          w = -1;
          for (int k = 0; k < NREQ; k++)
            if (w < 0 && req_bit(prev_req, (ptr + k) % NREQ)) w = (ptr + k) % NREQ;
          chk("grant", bus.grant, onehot(w));
          chk("eng_start", eng_start, 1'b1);
          chk("eng_entry", eng_entry, ent_at(prev_ent, w));
          grant_log.push_back(w);
          owner = w; gcyc = cyc; active = 1'b1;
        end else begin
          chk("no_grant", bus.grant, '0);
          chk("no_start", eng_start, 1'b0);
        end
        chk("busy", busy, active);
        chk("jobs_done", jobs_done, 8'(jobs));
        if (bus.rsp_valid != '0) begin
          if (!dlv) begin
            if (!active || exp_q[owner].size() == 0) begin
              chk("unexpected_rsp", bus.rsp_valid, '0);
            end else begin
              e = exp_q[owner].pop_front();
              chk("rsp_valid", bus.rsp_valid, onehot(owner));
              chk("rsp_data", bus.rsp_data, e.data);
              chk("rsp_err", bus.rsp_err, e.err);
              chk("rsp_latency", cyc - gcyc, e.lat);
              chk("eng_abort", eng_abort, e.err);
              dlv = 1'b1; hdata = bus.rsp_data; herr = bus.rsp_err;
            end
          end else begin
            chk("rsp_valid_hold", bus.rsp_valid, onehot(owner));
            chk("rsp_data_hold", bus.rsp_data, hdata);
            chk("rsp_err_hold", bus.rsp_err, herr);
            chk("abort_once", eng_abort, 1'b0);
          end
          if (dlv && req_bit(bus.rsp_ready, owner)) hs = 1'b1;
        end else begin
          chk("no_abort", eng_abort, 1'b0);
          if (active && !dlv && exp_q[owner].size() > 0)
            if (cyc - gcyc == exp_q[owner][0].lat + 1)
              chk("rsp_late", cyc - gcyc, exp_q[owner][0].lat);
        end
        prev_idle = !active;
        prev_req  = bus.req;
        prev_ent  = bus.entry_bus;
      end
    end
  end

  task automatic wait_idle(input int maxc, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (n < maxc && !(all_empty() && bus.req == '0 && !busy));
    if (n >= maxc) begin
      checks++; errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles", name, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, bus.grant, '0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, '0);
    chk({tag, "_rsp_data"}, bus.rsp_data, '0);
    chk({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
    chk({tag, "_eng_start"}, eng_start, 1'b0);
    chk({tag, "_eng_entry"}, eng_entry, '0);
    chk({tag, "_eng_abort"}, eng_abort, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_jobs_done"}, jobs_done, '0);
  endtask

  initial begin : global_limit
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin : main
    int n, a0;
    int exp_rr[8];
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("reset");
    @(negedge clk); #2;
    rst = 1'b1;

    // Single job from requester 0.
    todo_q[0].push_back(4'd6);
    wait_idle(200, "single");
    chk("single_jobs_done", jobs_done, 8'd1);
    chk("single_busy", busy, 1'b0);
    chk("single_grant_count", grant_log.size(), 1);
    if (grant_log.size() > 0) chk("single_grant_id", grant_log[0], 0);

    // All four requesters held high, two jobs each; pointer starts at 1.
    grant_log.delete();
    exp_rr = '{1, 2, 3, 0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) begin
      todo_q[i].push_back(4'(i + 1));
      todo_q[i].push_back(4'(i + 1));
    end
    wait_idle(400, "rr");
    chk("rr_grant_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("rr_order", grant_log[i], exp_rr[i]);
    chk("rr_jobs_done", jobs_done, 8'd9);

    // Backpressure on requester 2 while requester 0 says ready.
    ready_mode = 2;
    ready_man = 4'b0001;
    todo_q[2].push_back(4'd7);
    n = 0;
    while (bus.rsp_valid[2] !== 1'b1 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("bp_valid_arrived", n < 100, 1'b1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); #1;
      chk("bp_valid", bus.rsp_valid, 4'b0100);
      chk("bp_data", bus.rsp_data, 8'd15);
      chk("bp_start", eng_start, 1'b0);
    end
    ready_man = 4'b0101;
    wait_idle(50, "bp");
    chk("bp_jobs_done", jobs_done, 8'd10);
    ready_mode = 0;

    // Engine hangs: exactly one abort, error response.
    a0 = abort_cnt;
    eng_mode = 2;
    todo_q[1].push_back(4'd9);
    wait_idle(200, "timeout");
    chk("timeout_abort_count", abort_cnt - a0, 1);

    // Done lands on the final watchdog cycle: real result, no abort.
    a0 = abort_cnt;
    eng_mode = 1;
    todo_q[3].push_back(4'd5);
    wait_idle(200, "race");
    chk("race_abort_count", abort_cnt - a0, 0);

    // Randomized jobs, engine behaviour and response backpressure.
    for (int chunk = 0; chunk < 4; chunk++) begin
      eng_mode = (chunk == 0) ? 0 : int'($urandom_range(2, 0));
      ready_mode = 1;
      for (int j = 0; j < 10; j++)
        todo_q[$urandom_range(NREQ - 1, 0)].push_back(4'($urandom_range(15, 0)));
      wait_idle(3000, "random");
    end
    ready_mode = 0;
    eng_mode = 0;

    // Leave the pointer at 3, then reset in the middle of requester 3's run.
    todo_q[2].push_back(4'd3);
    wait_idle(200, "pre_reset");
    todo_q[3].push_back(4'd4);
    n = 0;
    while (eng_start !== 1'b1 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reset_job_started", n < 50, 1'b1);
    repeat (4) @(negedge clk);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("post_reset_jobs_done", jobs_done, 8'd0);
    grant_log.delete();
    todo_q[1].push_back(4'd2);
    todo_q[3].push_back(4'd3);
    wait_idle(200, "post_reset");
    chk("post_reset_grant_count", grant_log.size(), 2);
    if (grant_log.size() > 1) begin
      chk("post_reset_first", grant_log[0], 1);
      chk("post_reset_second", grant_log[1], 3);
    end
    chk("post_reset_jobs", jobs_done, 8'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
